// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 memory responder: controller state
// encoding and default geometry/timing.
package mips32_mem_pkg;

  localparam int MEM_DEPTH_DEF = 1024;
  localparam int MEM_WAIT_DEF  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mips32_rr_arb2.sv
// Two-way round-robin arbiter between the fetch and data request ports.
// The last-grant flag moves only when a grant is actually accepted.
module mips32_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_d,
  input  logic accept,
  output logic gnt_if,
  output logic gnt_d
);

  logic last_d;

  // On a tie, the port that did not win last time is granted.
  always_comb begin
    gnt_if = req_if & (~req_d | last_d);
    gnt_d  = req_d  & (~req_if | ~last_d);
  end

  // Reset leaves data as the last winner so fetch takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (accept) begin
      last_d <= gnt_d;
    end
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Single-ported word memory serving a MIPS32 fetch port and data port,
// one transaction at a time: IDLE -> WAIT x WAIT_CYCLES -> RESP.
// Optional build macro MIPS32_MEM_ADDR_ERR_EN: out-of-range addresses
// return an error response (rdata 0, store dropped) instead of wrapping.
module mips32_mem_responder
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH       = MEM_DEPTH_DEF,
  parameter int WAIT_CYCLES = MEM_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam mem_state_e ACC_NEXT = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;

  mem_state_e        state_q, state_d;
  logic [3:0]        wait_cnt;
  logic              accept;
  logic              gnt_if, gnt_d;
  logic              pend_d, we_q, err_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       sel_addr;
  logic              addr_hi_err;
  logic [31:0]       rd_word;
  logic [31:0]       mem [DEPTH];

  mips32_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_if (if_req_valid),
    .req_d  (d_req_valid),
    .accept (accept),
    .gnt_if (gnt_if),
    .gnt_d  (gnt_d)
  );

  assign sel_addr = gnt_d ? d_addr : if_addr;
  assign rd_word  = mem[addr_q];

`ifdef MIPS32_MEM_ADDR_ERR_EN
  assign addr_hi_err = |sel_addr[31:AW];
`else
  // Upper address bits are deliberately ignored: addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_addr[31:AW];
  assign addr_hi_err    = 1'b0;
`endif

  // Next state, readies and the one-cycle response from the current state.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if_rsp_valid = 1'b0;
    if_rdata     = 32'd0;
    if_rsp_err   = 1'b0;
    d_rsp_valid  = 1'b0;
    d_rdata      = 32'd0;
    d_rsp_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if_req_ready = gnt_if;
        d_req_ready  = gnt_d;
        accept       = gnt_if | gnt_d;
        if (accept) state_d = ACC_NEXT;
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (pend_d) begin
          d_rsp_valid = 1'b1;
          d_rsp_err   = err_q;
          d_rdata     = (we_q || err_q) ? 32'd0 : rd_word;
        end else begin
          if_rsp_valid = 1'b1;
          if_rsp_err   = err_q;
          if_rdata     = err_q ? 32'd0 : rd_word;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, wait down-counter and request capture at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_cnt <= 4'd0;
      pend_d   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_d   <= gnt_d;
        we_q     <= gnt_d & d_we;
        err_q    <= addr_hi_err;
        addr_q   <= sel_addr[AW-1:0];
        wdata_q  <= d_wdata;
        wait_cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state_q == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Store commits on the edge leaving RESP; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_RESP && we_q && !err_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench for mips32_mem_responder: one instance with one wait
// state, one with zero wait states (fetch port only).
module tb_mips32_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;

  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_addr = 32'd0;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rdata;
  logic        d_req_valid = 1'b0, d_req_ready, d_we = 1'b0;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rdata;

  logic        w0_if_req_valid = 1'b0, w0_if_req_ready;
  logic [31:0] w0_if_addr = 32'd0;
  logic        w0_if_rsp_valid, w0_if_rsp_err;
  logic [31:0] w0_if_rdata;
  logic        w0_d_req_ready, w0_d_rsp_valid, w0_d_rsp_err;
  logic [31:0] w0_d_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips32_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_rsp_err(d_rsp_err)
  );

  mips32_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req_valid(w0_if_req_valid), .if_req_ready(w0_if_req_ready), .if_addr(w0_if_addr),
    .if_rsp_valid(w0_if_rsp_valid), .if_rdata(w0_if_rdata), .if_rsp_err(w0_if_rsp_err),
    .d_req_valid(1'b0), .d_req_ready(w0_d_req_ready), .d_we(1'b0),
    .d_addr(32'd0), .d_wdata(32'd0),
    .d_rsp_valid(w0_d_rsp_valid), .d_rdata(w0_d_rdata), .d_rsp_err(w0_d_rsp_err)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // One data transaction; rsp_cyc uses the numbering where the cycle
  // ending at edge k is cycle k, so a response is due at acc_edge+1+W.
  task automatic d_xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int acc_edge,
                        output int rsp_cyc, output logic ok, output logic pulse_ok,
                        output logic other_v);
    ok = 1'b0; pulse_ok = 1'b0; rd = 32'd0; err = 1'b0; other_v = 1'b0;
    acc_edge = -1; rsp_cyc = -1;
    @(negedge clk);
    d_req_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (d_req_ready) break;
      @(negedge clk); #1;
    end
    if (!d_req_ready) begin
      d_req_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    @(negedge clk);
    d_req_valid = 1'b0; d_we = ~we; d_addr = ~addr; d_wdata = ~wd;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (d_rsp_valid) begin
        rd = d_rdata; err = d_rsp_err; other_v = if_rsp_valid;
        rsp_cyc = cyc + 1; ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    pulse_ok = !d_rsp_valid && d_rdata == 32'd0 && !d_rsp_err;
  endtask

  task automatic f_xact(input logic [31:0] addr, output logic [31:0] rd, output logic err,
                        output int acc_edge, output int rsp_cyc, output logic ok,
                        output logic other_v);
    ok = 1'b0; rd = 32'd0; err = 1'b0; other_v = 1'b0; acc_edge = -1; rsp_cyc = -1;
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = addr;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (if_req_ready) break;
      @(negedge clk); #1;
    end
    if (!if_req_ready) begin
      if_req_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    @(negedge clk);
    if_req_valid = 1'b0; if_addr = ~addr;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (if_rsp_valid) begin
        rd = if_rdata; err = if_rsp_err; other_v = d_rsp_valid;
        rsp_cyc = cyc + 1; ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({if_rsp_valid, d_rsp_valid} !== 2'b00) $display("FAIL reset_valid: got %b want 00", {if_rsp_valid, d_rsp_valid}); else passed++;
    total++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata); else passed++;
    total++; if ({if_rsp_err, d_rsp_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {if_rsp_err, d_rsp_err}); else passed++;
    total++; if ({if_req_ready, d_req_ready} !== 2'b00) $display("FAIL reset_ready_idle: got %b want 00", {if_req_ready, d_req_ready}); else passed++;
    @(negedge clk);
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    total++; if ({if_req_ready, d_req_ready} !== 2'b10) $display("FAIL reset_first_tie: got %b want 10", {if_req_ready, d_req_ready}); else passed++;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er, ok, pl, ov; int ae, rc;
    d_xact(1'b1, 32'd100, 32'hDEADBEEF, rd, er, ae, rc, ok, pl, ov);
    total++; if (!ok) $display("FAIL store_rsp_timeout: got no response want one"); else passed++;
    total++; if (rd !== 32'd0 || er !== 1'b0) $display("FAIL store_ack: got rdata %h err %b want 0 0", rd, er); else passed++;
    total++; if (rc !== ae + 2) $display("FAIL store_latency: got cycle %0d want %0d", rc, ae + 2); else passed++;
    total++; if (ov !== 1'b0) $display("FAIL store_other_port: got if_rsp_valid %b want 0", ov); else passed++;
    total++; if (!pl) $display("FAIL store_pulse: got response beyond one cycle want single pulse"); else passed++;
    d_xact(1'b0, 32'd100, 32'h0, rd, er, ae, rc, ok, pl, ov);
    total++; if (!ok || rd !== 32'hDEADBEEF) $display("FAIL load_100: got %h want deadbeef", rd); else passed++;
    total++; if (!pl) $display("FAIL load_pulse: got response beyond one cycle want single pulse"); else passed++;
  endtask

  task automatic test_fetch();
    logic [31:0] rd; logic er, ok, pl, ov; int ae, rc;
    d_xact(1'b1, 32'd5, 32'h2A000000, rd, er, ae, rc, ok, pl, ov);
    f_xact(32'd5, rd, er, ae, rc, ok, ov);
    total++; if (!ok || rd !== 32'h2A000000) $display("FAIL fetch_5: got %h want 2a000000", rd); else passed++;
    total++; if (rc !== ae + 2) $display("FAIL fetch_latency: got cycle %0d want %0d", rc, ae + 2); else passed++;
    total++; if (er !== 1'b0 || ov !== 1'b0) $display("FAIL fetch_err_other: got err %b d_valid %b want 0 0", er, ov); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] gnt;
    int         edge_at [4];
    bit         seen;
    do_reset();
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 32'd5;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'd100;
    #1;
    gnt = 4'b0;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      edge_at[k] = -100;
      for (int i = 0; i < 10; i++) begin
        if (if_req_ready || d_req_ready) begin seen = 1'b1; break; end
        @(negedge clk); #1;
      end
      total++; if (!seen) $display("FAIL rr_grant_timeout_%0d: got no ready want one", k); else passed++;
      total++; if (if_req_ready && d_req_ready) $display("FAIL rr_both_ready_%0d: got 11 want one-hot", k); else passed++;
      gnt[k] = d_req_ready;
      edge_at[k] = cyc + 1;
      @(negedge clk); #1;
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    total++; if (gnt !== 4'b1010) $display("FAIL rr_order: got %b (bit k = data won k) want 1010", gnt); else passed++;
    for (int k = 1; k < 4; k++) begin
      total++; if (edge_at[k] - edge_at[k-1] !== 3) $display("FAIL rr_spacing_%0d: got %0d want 3", k, edge_at[k] - edge_at[k-1]); else passed++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, ok, pl, ov; int ae, rc; int pulses;
    d_xact(1'b1, 32'd7, 32'h11111111, rd, er, ae, rc, ok, pl, ov);
    @(negedge clk);
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h55555555;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (d_req_ready) break;
      @(negedge clk); #1;
    end
    total++; if (!d_req_ready) $display("FAIL midrst_accept: got ready 0 want 1"); else passed++;
    @(negedge clk);
    d_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (d_rsp_valid) pulses++;
      @(negedge clk);
    end
    total++; if (pulses !== 0) $display("FAIL midrst_no_rsp: got %0d responses want 0", pulses); else passed++;
    d_xact(1'b0, 32'd7, 32'h0, rd, er, ae, rc, ok, pl, ov);
    total++; if (!ok || rd !== 32'h11111111) $display("FAIL midrst_mem7: got %h want 11111111", rd); else passed++;
  endtask

  task automatic test_addr_err();
    logic [31:0] rd; logic er, ok, pl, ov; int ae, rc;
    logic [31:0] exp_ld; logic exp_er; logic [31:0] exp_m0;
`ifdef MIPS32_MEM_ADDR_ERR_EN
    exp_ld = 32'd0; exp_er = 1'b1; exp_m0 = 32'h0BADF00D;
`else
    exp_ld = 32'h0BADF00D; exp_er = 1'b0; exp_m0 = 32'h12345678;
`endif
    d_xact(1'b1, 32'd0, 32'h0BADF00D, rd, er, ae, rc, ok, pl, ov);
    d_xact(1'b0, 32'd1024, 32'h0, rd, er, ae, rc, ok, pl, ov);
    total++; if (!ok || rd !== exp_ld) $display("FAIL oor_load_data: got %h want %h", rd, exp_ld); else passed++;
    total++; if (er !== exp_er) $display("FAIL oor_load_err: got %b want %b", er, exp_er); else passed++;
    d_xact(1'b1, 32'd1024, 32'h12345678, rd, er, ae, rc, ok, pl, ov);
    total++; if (!ok || er !== exp_er) $display("FAIL oor_store_err: got %b want %b", er, exp_er); else passed++;
    d_xact(1'b0, 32'd0, 32'h0, rd, er, ae, rc, ok, pl, ov);
    total++; if (!ok || rd !== exp_m0) $display("FAIL oor_store_effect: got %h want %h", rd, exp_m0); else passed++;
  endtask

  task automatic test_back_to_back_w0();
    logic exp_rdy, exp_rsp;
    do_reset();
    @(negedge clk);
    w0_if_req_valid = 1'b1; w0_if_addr = 32'd3;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_rdy = (i % 2 == 0);
      exp_rsp = (i % 2 == 1);
      total++; if (w0_if_req_ready !== exp_rdy) $display("FAIL w0_ready_%0d: got %b want %b", i, w0_if_req_ready, exp_rdy); else passed++;
      total++; if (w0_if_rsp_valid !== exp_rsp) $display("FAIL w0_rsp_%0d: got %b want %b", i, w0_if_rsp_valid, exp_rsp); else passed++;
      @(negedge clk); #1;
    end
    w0_if_req_valid = 1'b0;
    total++; if (w0_d_rsp_valid !== 1'b0 || w0_d_rdata !== 32'd0) $display("FAIL w0_data_idle: got %b/%h want 0/0", w0_d_rsp_valid, w0_d_rdata); else passed++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_fetch();
    test_round_robin();
    test_reset_mid();
    test_addr_err();
    test_back_to_back_w0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips32_mem_responder.md
MIPS32_MEM_RESPONDER -- requirements
Module: mips32_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of two); AW = log2(DEPTH).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning wait states inserted between accept and response (0..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-005 SHALL have port if_req_valid, input, 1, meaning an instruction-fetch read request is present.
REQ-006 SHALL have port if_req_ready, output, 1, meaning the instruction request is accepted this cycle.
REQ-007 SHALL have port if_addr, input, 32, meaning the fetch word address.
REQ-008 SHALL have port if_rsp_valid, output, 1, meaning a one-cycle pulse qualifying if_rdata.
REQ-009 SHALL have port if_rdata, output, 32, meaning the fetched instruction word.
REQ-010 SHALL have port d_req_valid, input, 1, meaning a data request is present.
REQ-011 SHALL have port d_req_ready, output, 1, meaning the data request is accepted this cycle.
REQ-012 SHALL have port d_we, input, 1, meaning 1 = store and 0 = load.
REQ-013 SHALL have port d_addr, input, 32, meaning the data word address.
REQ-014 SHALL have port d_wdata, input, 32, meaning the store data.
REQ-015 SHALL have port d_rsp_valid, output, 1, meaning a one-cycle pulse for load data or store acknowledge.
REQ-016 SHALL have port d_rdata, output, 32, meaning the load data, or 0 on a store acknowledge.
REQ-017 SHALL have port if_rsp_err, output, 1, meaning an address error on the fetch response.
REQ-018 SHALL have port d_rsp_err, output, 1, meaning an address error on the data response.

Function
REQ-019 SHALL implement FSM IDLE, WAIT, RESP: IDLE→WAIT on accept when WAIT_CYCLES>0, else IDLE→RESP; WAIT→RESP after WAIT_CYCLES cycles; RESP→IDLE unconditionally.
REQ-020 SHALL assert at most one ready, only in IDLE, and only to the granted valid port; ready is combinational from state, valids and arbiter.
REQ-021 SHALL arbitrate round-robin: when both valids are high in IDLE, grant the port not granted last; a sole requester is always granted.
REQ-022 SHALL register address, we and wdata of the granted port at accept; inputs are ignored after accept.
REQ-023 SHALL raise the granted port's rsp_valid exactly in the RESP cycle, i.e. cycle N+1+WAIT_CYCLES for accept at edge N; no response backpressure.
REQ-024 SHALL perform a store's memory write on the edge ending RESP; a load in the same or a later transaction sees the new value.
REQ-025 SHALL hold rdata/err at 0 whenever rsp_valid is 0; the non-granted port's outputs stay 0.
REQ-026 SHALL sustain one transaction per WAIT_CYCLES+2 cycles back-to-back (IDLE, WAIT×n, RESP).

Reset
REQ-027 SHALL on rst: state=IDLE, wait counter=0, all rsp_valid/rdata/err=0, last-grant=data (fetch wins first tie); memory contents not reset.
REQ-028 SHALL on rst mid-transaction drop the pending request: no response issued and no memory write performed.

Configuration
REQ-029 SHALL, with MIPS32_MEM_ADDR_ERR_EN defined, flag any address ≥ DEPTH: rsp_err=1 with rsp_valid, rdata=0, store suppressed.
REQ-030 SHALL, without MIPS32_MEM_ADDR_ERR_EN, use address bits [AW-1:0] only (wrap-around), with both err outputs tied to 0.

Structure
REQ-031 SHALL take the FSM state enum and the DEPTH/WAIT_CYCLES defaults from shared package mips32_mem_pkg.
REQ-032 SHALL instantiate sub-module mips32_rr_arb2 (2-way round-robin arbiter, last-grant register, update on accept only).

Verification
REQ-033 SHALL check: WAIT_CYCLES=1, fetch addr 5 preloaded 0x2A000000 accepted at edge 10 → if_rsp_valid in cycle 12 with if_rdata=0x2A000000.
REQ-034 SHALL check: store 0xDEADBEEF to addr 100, then load addr 100 → d_rdata=0xDEADBEEF, store ack d_rdata=0.
REQ-035 SHALL check: both valids held high for 4 transactions after reset → grants fetch, data, fetch, data.
REQ-036 SHALL check: rst asserted in WAIT of a store to addr 7 → no d_rsp_valid; Mem[7] unchanged.
REQ-037 SHALL check: load addr 1024 → d_rsp_err=1, d_rdata=0 with macro; without it, d_rdata=Mem[0] and err=0.
REQ-038 SHALL check: WAIT_CYCLES=0, back-to-back fetches → one response every 2 cycles, ready low in RESP.
